controle_multiciclo: RTL and testbench
======================================

# controle_multiciclo

Multicycle control sequencer for the RV32 subset core: lw, sw, addi, add, sub, xor, srl, and, or, beq, bne. It owns the instruction register and the `estado` state register. Each cycle it drives PC/IR/register-file/data-memory enables and the ALU control code, which makes it the sole source of sequencing for the datapath. It also waits on a data-memory ready handshake with a bounded timeout and counts retired instructions.

## Interface
- MEM_TIMEOUT, 15: max cycles spent in MEM without `mem_ready` before fault (1..255)
- CNT_W, 32: width of retired-instruction counter
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- instr  in  32  instruction memory read data (combinational, valid every cycle)
- zero  in  1  ALU zero flag
- mem_ready  in  1  data memory completes the current access this cycle
- estado  out  4  current state code
- pcwrite  out  1  PC register load enable
- pcsrc  out  1  0 = PC+4, 1 = branch target
- irwrite  out  1  IR load enable (mirrors internal IR load)
- regwrite  out  1  register file write enable
- memread  out  1  data memory read request
- memwrite  out  1  data memory write request
- alusrc  out  1  0 = rs2, 1 = immediate
- memtoreg  out  1  write-back source: 1 = memory, 0 = ALU
- alucontrol  out  4  ALU operation code
- erro  out  1  sticky fault flag (illegal instruction or memory timeout)
- ninstr  out  CNT_W  retired-instruction count

## Operation
- State codes: FETCH 0000, DECODE 0001, EXECUTE 0010, MEM 0100, BRANCH 0110, ERRO 1000, WRITEBACK 1111.
- tipo = IR[6:4]: 000 lw, 001 addi, 010 sw, 011 R-type, 110 branch. Any other tipo is illegal.
- Illegal encodings also include:
  - R-type with funct3 not in {000,100,101,110,111}
  - R-type funct3 000 with funct7[6:5] not in {00,01}
  - branch with funct3 not in {000,001}
- Transitions:
  - FETCH→DECODE always.
  - DECODE→BRANCH for branch; →ERRO if illegal; otherwise →EXECUTE.
  - EXECUTE→MEM for lw/sw; →WRITEBACK for addi/R-type.
  - MEM→WRITEBACK (lw) or →FETCH (sw) on `mem_ready`; →ERRO on timeout.
  - WRITEBACK→FETCH.
  - BRANCH→FETCH.
  - ERRO→ERRO until reset.
- Outputs are decoded from the registered state plus IR. All enables are 0 unless listed below.
  - FETCH: irwrite=1, pcwrite=1, pcsrc=0. IR loads `instr` at the closing edge.
  - EXECUTE, MEM, WRITEBACK: alucontrol per op, held stable across all three states. lw/sw 0010, addi 0011, add 0010, sub 0110, xor 0100, srl 0101, and 0000, or 0001.
  - alusrc=1 for lw/sw/addi; alusrc=0 for R-type.
  - MEM: memread=1 (lw) or memwrite=1 (sw), held until the cycle `mem_ready`=1 inclusive.
  - WRITEBACK: regwrite=1 for exactly one cycle. memtoreg=1 for lw, 0 otherwise.
  - BRANCH: alucontrol=0110, alusrc=0. Taken = (funct3 000 & zero) | (funct3 001 & !zero). pcwrite=taken, pcsrc=1.
  - ERRO: erro=1, all enables 0, alucontrol 0000.
  - alucontrol=0000 in FETCH and DECODE.
- Timeout counter:
  - Clears on MEM entry and increments each MEM cycle with `mem_ready`=0.
  - When it reaches MEM_TIMEOUT with `mem_ready` still 0, next state is ERRO.
  - `mem_ready`=1 in the same cycle as the limit wins: normal completion.
- ninstr increments by 1 on leaving WRITEBACK, on BRANCH→FETCH, and on sw MEM→FETCH. It wraps modulo 2^CNT_W and never increments in ERRO.

## Timing
- Reset values:
  - estado 0000 (FETCH), IR 0, ninstr 0, timeout counter 0, erro 0.
  - From the decoded reset state: irwrite=1, pcwrite=1, pcsrc=0. Every other output is 0.
- Reset asserted mid-instruction: the next state is FETCH on that edge. No pending regwrite/memwrite is issued after the edge.
- Latency, edge-to-edge, zero-wait memory:
  - R-type/addi: 4 cycles.
  - branch: 3 cycles.
  - sw: 4 cycles.
  - lw: 5 cycles.
  - Each MEM wait cycle adds 1.
- `mem_ready` is sampled only in MEM and ignored in every other state.
- `zero` is sampled only in BRANCH.
- Memory request signals may not drop before `mem_ready`. Once `mem_ready`=1 they are deasserted the next cycle.

## Test plan
- Reset, then add (IR 0x002081B3): estado sequence 0000,0001,0010,1111,0000. alucontrol=0010 in EXECUTE/WB. regwrite=1 only in WB. ninstr=1.
- sub (funct7 0100000), then xor, srl, and, or, addi: alucontrol 0110, 0100, 0101, 0000, 0001, 0011 respectively. alusrc=1 only for addi.
- lw with `mem_ready` low for 3 cycles: memread high 4 cycles. WB has memtoreg=1, regwrite=1. Total 8 cycles.
- sw with `mem_ready` never high, MEM_TIMEOUT=15: memwrite high 15 cycles, then estado=1000, erro=1, memwrite=0. State sticky until reset. reset→estado 0000, erro 0.
- beq with zero=1: pcwrite=1, pcsrc=1 in BRANCH. beq with zero=0: pcwrite=0. bne inverts both cases. Each branch takes 3 cycles and increments ninstr.
- Illegal opcode 0x7F (tipo 111) → ERRO from DECODE, ninstr unchanged. Reset asserted during lw MEM → FETCH next cycle with memread=0.

Source files
------------

// File: rtl/controle_multiciclo.sv
// Multicycle control sequencer for the RV32 subset: owns IR and state, drives datapath enables and ALU code.
// 3 (branch) / 4 (ALU, sw) / 5 (lw) cycles per instruction; MEM stalls on mem_ready and faults after MEM_TIMEOUT waits.
module controle_multiciclo #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic             zero,
    input  logic             mem_ready,
    output logic [3:0]       estado,
    output logic             pcwrite,
    output logic             pcsrc,
    output logic             irwrite,
    output logic             regwrite,
    output logic             memread,
    output logic             memwrite,
    output logic             alusrc,
    output logic             memtoreg,
    output logic [3:0]       alucontrol,
    output logic             erro,
    output logic [CNT_W-1:0] ninstr
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'b0000,
        S_DECODE  = 4'b0001,
        S_EXECUTE = 4'b0010,
        S_MEM     = 4'b0100,
        S_BRANCH  = 4'b0110,
        S_ERRO    = 4'b1000,
        S_WB      = 4'b1111
    } state_t;

    localparam logic [7:0]       TMO_LAST = 8'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [31:0]      ir_q, ir_d;
    logic [7:0]       tmo_q, tmo_d;
    logic [CNT_W-1:0] ninstr_q, ninstr_d;

    logic [2:0] tipo, f3;
    logic [1:0] f7h;
    logic       is_lw, is_sw, is_addi, is_r, is_br, illegal;
    logic [3:0] alu_op;

    // Only opcode/funct fields steer control; operand fields belong to the datapath.
    logic unused_ir_bits;
    assign unused_ir_bits = ^{ir_q[29:15], ir_q[11:7], ir_q[3:0]};

    assign tipo    = ir_q[6:4];
    assign f3      = ir_q[14:12];
    assign f7h     = ir_q[31:30];
    assign is_lw   = (tipo == 3'b000);
    assign is_addi = (tipo == 3'b001);
    assign is_sw   = (tipo == 3'b010);
    assign is_r    = (tipo == 3'b011);
    assign is_br   = (tipo == 3'b110);
    assign illegal = !(is_lw || is_addi || is_sw
                       || (is_r && (f3[2] || (f3 == 3'b000 && !f7h[1])))
                       || (is_br && f3[2:1] == 2'b00));

    always_comb begin
        alu_op = 4'b0000;
        if (is_lw || is_sw) begin
            alu_op = 4'b0010;
        end else if (is_addi) begin
            alu_op = 4'b0011;
        end else if (is_r) begin
            case (f3)
                3'b000:  alu_op = f7h[0] ? 4'b0110 : 4'b0010;
                3'b100:  alu_op = 4'b0100;
                3'b101:  alu_op = 4'b0101;
                3'b110:  alu_op = 4'b0001;
                default: alu_op = 4'b0000;
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        tmo_d    = tmo_q;
        ninstr_d = ninstr_q;
        case (state_q)
            S_FETCH: begin
                ir_d    = instr;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (illegal)    state_d = S_ERRO;
                else if (is_br) state_d = S_BRANCH;
                else            state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                if (is_lw || is_sw) begin
                    state_d = S_MEM;
                    tmo_d   = 8'd0;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                // A completion on the limit cycle still counts as success.
                if (mem_ready) begin
                    if (is_sw) begin
                        state_d  = S_FETCH;
                        ninstr_d = ninstr_q + CNT_ONE;
                    end else begin
                        state_d = S_WB;
                    end
                end else begin
                    tmo_d = tmo_q + 8'd1;
                    if (tmo_q == TMO_LAST) state_d = S_ERRO;
                end
            end
            S_WB, S_BRANCH: begin
                state_d  = S_FETCH;
                ninstr_d = ninstr_q + CNT_ONE;
            end
            S_ERRO:  state_d = S_ERRO;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_FETCH;
            ir_q     <= 32'd0;
            tmo_q    <= 8'd0;
            ninstr_q <= '0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            tmo_q    <= tmo_d;
            ninstr_q <= ninstr_d;
        end
    end

    always_comb begin
        pcwrite    = 1'b0;
        pcsrc      = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        memread    = 1'b0;
        memwrite   = 1'b0;
        alusrc     = 1'b0;
        memtoreg   = 1'b0;
        alucontrol = 4'b0000;
        erro       = 1'b0;
        case (state_q)
            S_FETCH: begin
                irwrite = 1'b1;
                pcwrite = 1'b1;
            end
            S_EXECUTE, S_MEM, S_WB: begin
                alucontrol = alu_op;
                alusrc     = is_lw || is_sw || is_addi;
                if (state_q == S_MEM) begin
                    memread  = is_lw;
                    memwrite = is_sw;
                end
                if (state_q == S_WB) begin
                    regwrite = 1'b1;
                    memtoreg = is_lw;
                end
            end
            S_BRANCH: begin
                alucontrol = 4'b0110;
                pcsrc      = 1'b1;
                pcwrite    = f3[0] ? !zero : zero;
            end
            S_ERRO:  erro = 1'b1;
            default: ;
        endcase
    end

    assign estado = state_q;
    assign ninstr = ninstr_q;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Self-checking bench: directed and random instructions against a per-instruction cycle-trace model.
module tb_controle_multiciclo;

    localparam int TMO = 15;
    localparam int K_ILL = 0, K_LW = 1, K_SW = 2, K_ADDI = 3, K_R = 4, K_BR = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr = 32'd0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic [3:0]  estado, alucontrol;
    logic        pcwrite, pcsrc, irwrite, regwrite, memread, memwrite, alusrc, memtoreg, erro;
    logic [31:0] ninstr;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] n_exp = 32'd0;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, pcs, irw, rgw, mrd, mwr, asrc, m2r;
        logic [3:0] alu;
        logic       err;
    } exp_t;

    typedef struct {
        exp_t e;
        logic rdy;
        logic zv;
    } step_t;

    exp_t obs;
    assign obs = {estado, pcwrite, pcsrc, irwrite, regwrite, memread, memwrite,
                  alusrc, memtoreg, alucontrol, erro};

    controle_multiciclo #(.MEM_TIMEOUT(TMO), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .estado(estado), .pcwrite(pcwrite), .pcsrc(pcsrc), .irwrite(irwrite),
        .regwrite(regwrite), .memread(memread), .memwrite(memwrite), .alusrc(alusrc),
        .memtoreg(memtoreg), .alucontrol(alucontrol), .erro(erro), .ninstr(ninstr)
    );

    always #5 clk = ~clk;

    function automatic exp_t rec(logic [3:0] st, logic pcw, logic pcs, logic irw, logic rgw,
                                 logic mrd, logic mwr, logic asrc, logic m2r,
                                 logic [3:0] alu, logic err);
        return {st, pcw, pcs, irw, rgw, mrd, mwr, asrc, m2r, alu, err};
    endfunction

    function automatic int classify(logic [31:0] w);
        logic [2:0] f3;
        logic [1:0] f7h;
        f3  = w[14:12];
        f7h = w[31:30];
        case (w[6:4])
            3'b000: return K_LW;
            3'b001: return K_ADDI;
            3'b010: return K_SW;
            3'b011: begin
                if (f3 == 3'b100 || f3 == 3'b101 || f3 == 3'b110 || f3 == 3'b111) return K_R;
                if (f3 == 3'b000 && (f7h == 2'b00 || f7h == 2'b01)) return K_R;
                return K_ILL;
            end
            3'b110: return (f3 == 3'b000 || f3 == 3'b001) ? K_BR : K_ILL;
            default: return K_ILL;
        endcase
    endfunction

    function automatic logic [3:0] alu_of(logic [31:0] w, int k);
        if (k == K_LW || k == K_SW) return 4'b0010;
        if (k == K_ADDI) return 4'b0011;
        case (w[14:12])
            3'b000:  return w[30] ? 4'b0110 : 4'b0010;
            3'b100:  return 4'b0100;
            3'b101:  return 4'b0101;
            3'b110:  return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        instr     = $urandom;
        zero      = 1'($urandom);
        mem_ready = 1'($urandom);
        @(posedge clk); #1;
        n_exp = 32'd0;
        chk("reset_ctl", 32'(obs), 32'(rec(4'h0, 1, 0, 1, 0, 0, 0, 0, 0, 4'h0, 0)));
        chk("reset_ninstr", ninstr, n_exp);
        reset = 1'b0;
    endtask

    // waits < 0: memory never answers. stop_at >= 0: assert reset during that cycle.
    task automatic do_instr(input logic [31:0] iw, input int waits, input logic zv, input int stop_at);
        step_t      q[$];
        int         k, nwait;
        logic [3:0] alu;
        logic       asrc, taken, lw;
        bit         retire, to_err;
        k      = classify(iw);
        alu    = alu_of(iw, k);
        asrc   = (k == K_LW || k == K_SW || k == K_ADDI);
        lw     = (k == K_LW);
        retire = 0;
        to_err = 0;
        q.push_back('{e: rec(4'h0, 1, 0, 1, 0, 0, 0, 0, 0, 4'h0, 0), rdy: 1'($urandom), zv: 1'($urandom)});
        q.push_back('{e: rec(4'h1, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0), rdy: 1'($urandom), zv: 1'($urandom)});
        if (k == K_ILL) begin
            to_err = 1;
        end else if (k == K_BR) begin
            taken = iw[12] ? !zv : zv;
            q.push_back('{e: rec(4'h6, taken, 1, 0, 0, 0, 0, 0, 0, 4'b0110, 0), rdy: 1'($urandom), zv: zv});
            retire = 1;
        end else begin
            q.push_back('{e: rec(4'h2, 0, 0, 0, 0, 0, 0, asrc, 0, alu, 0), rdy: 1'($urandom), zv: 1'($urandom)});
            if (k == K_LW || k == K_SW) begin
                nwait = (waits < 0) ? TMO : waits;
                for (int i = 0; i < nwait; i++)
                    q.push_back('{e: rec(4'h4, 0, 0, 0, 0, lw, !lw, asrc, 0, alu, 0), rdy: 1'b0, zv: 1'($urandom)});
                if (waits < 0) begin
                    to_err = 1;
                end else begin
                    q.push_back('{e: rec(4'h4, 0, 0, 0, 0, lw, !lw, asrc, 0, alu, 0), rdy: 1'b1, zv: 1'($urandom)});
                    if (lw)
                        q.push_back('{e: rec(4'hF, 0, 0, 0, 1, 0, 0, asrc, 1, alu, 0), rdy: 1'($urandom), zv: 1'($urandom)});
                    retire = 1;
                end
            end else begin
                q.push_back('{e: rec(4'hF, 0, 0, 0, 1, 0, 0, asrc, 0, alu, 0), rdy: 1'($urandom), zv: 1'($urandom)});
                retire = 1;
            end
        end
        if (to_err)
            for (int i = 0; i < 3; i++)
                q.push_back('{e: rec(4'h8, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 1), rdy: 1'($urandom), zv: 1'($urandom)});
        foreach (q[i]) begin
            instr     = (i == 0) ? iw : $urandom;
            mem_ready = q[i].rdy;
            zero      = q[i].zv;
            #1;
            chk($sformatf("ctl_%08h_c%0d", iw, i), 32'(obs), 32'(q[i].e));
            chk($sformatf("ninstr_%08h_c%0d", iw, i), ninstr, n_exp);
            if (i == stop_at) begin
                do_reset();
                return;
            end
            @(posedge clk); #1;
        end
        if (retire) n_exp = n_exp + 32'd1;
        if (to_err) do_reset();
    endtask

    initial begin
        do_reset();
        do_instr(32'h002081B3, 0, 1'b0, -1);   // add
        do_instr(32'h402081B3, 0, 1'b0, -1);   // sub
        do_instr(32'h0020C1B3, 0, 1'b0, -1);   // xor
        do_instr(32'h0020D1B3, 0, 1'b0, -1);   // srl
        do_instr(32'h0020F1B3, 0, 1'b0, -1);   // and
        do_instr(32'h0020E1B3, 0, 1'b0, -1);   // or
        do_instr(32'h00508093, 0, 1'b0, -1);   // addi
        do_instr(32'h0000A183, 3, 1'b0, -1);   // lw, 3 wait cycles
        do_instr(32'h0000A183, 0, 1'b0, -1);
        do_instr(32'h0030A023, 0, 1'b0, -1);   // sw
        do_instr(32'h0030A023, TMO - 1, 1'b0, -1);
        do_instr(32'h00208063, 0, 1'b1, -1);   // beq taken
        do_instr(32'h00208063, 0, 1'b0, -1);
        do_instr(32'h00209063, 0, 1'b1, -1);   // bne
        do_instr(32'h00209063, 0, 1'b0, -1);
        chk("ninstr_before_fault", ninstr, 32'd15);
        do_instr(32'h0030A023, -1, 1'b0, -1);  // sw timeout
        do_instr(32'h002081B3, 0, 1'b0, -1);
        do_instr(32'h0000007F, 0, 1'b0, -1);   // illegal tipo
        do_instr(32'h00208063, 0, 1'b1, -1);
        do_instr(32'h002091B3, 0, 1'b0, -1);   // R-type funct3 001
        do_instr(32'h00208063, 0, 1'b1, -1);
        do_instr(32'h802081B3, 0, 1'b0, -1);   // R-type funct7[6:5]=10
        do_instr(32'h0020A063, 0, 1'b0, -1);   // branch funct3 010
        do_instr(32'h00508093, 0, 1'b0, -1);
        do_instr(32'h0000A183, 3, 1'b0, 4);    // reset during lw MEM
        do_instr(32'h0030A023, 2, 1'b0, 3);    // reset during sw MEM
        do_instr(32'h00508093, 0, 1'b0, 2);    // reset during addi EXECUTE
        for (int n = 0; n < 80; n++) begin
            logic [31:0] w;
            int          sel, wt;
            w   = $urandom;
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1:    w[6:4] = 3'b000;
                2, 3:    w[6:4] = 3'b010;
                4:       w[6:4] = 3'b001;
                5, 6, 7: begin
                    w[6:4] = 3'b011;
                    if ($urandom_range(0, 3) != 0) w[31] = 1'b0;
                end
                8: begin
                    w[6:4] = 3'b110;
                    if ($urandom_range(0, 3) != 0) w[14:13] = 2'b00;
                end
                default: ;
            endcase
            wt = ($urandom_range(0, 7) == 0) ? TMO - 1 : $urandom_range(0, 4);
            do_instr(w, wt, 1'($urandom), -1);
        end
        chk("final_ninstr", ninstr, n_exp);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
